// File: rtl/cosim_commit_queue.sv
// Retire-to-checker ordering queue for Spike co-simulation.
// Up to two commits plus one mip marker are enqueued per cycle, all-or-nothing.
module cosim_commit_queue #(
  parameter int DEPTH   = 16,
  parameter int XLEN    = 64,
  parameter int HART_ID = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [1:0]                commit_valid_i,
  input  logic [2*XLEN-1:0]         commit_pc_i,
  input  logic [63:0]               commit_ins_i,
  input  logic [9:0]                commit_dst_i,
  input  logic [1:0]                commit_we_i,
  input  logic [2*XLEN-1:0]         commit_data_i,
  input  logic [1:0]                commit_xcpt_i,
  input  logic [2*XLEN-1:0]         commit_cause_i,
  input  logic [XLEN-1:0]           mip_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic                      out_kind_o,
  output logic [XLEN-1:0]           out_pc_o,
  output logic [31:0]               out_ins_o,
  output logic [4:0]                out_dst_o,
  output logic                      out_we_o,
  output logic [XLEN-1:0]           out_data_o,
  output logic                      out_xcpt_o,
  output logic [XLEN-1:0]           out_cause_o,
  output logic [31:0]               out_seq_o,
  output logic [31:0]               out_hart_o,
  output logic [$clog2(DEPTH):0]    count_o,
  output logic                      stall_o,
  output logic                      overflow_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic            kind;
    logic [XLEN-1:0] pc;
    logic [31:0]     ins;
    logic [4:0]      dst;
    logic            we;
    logic [XLEN-1:0] data;
    logic            xcpt;
    logic [XLEN-1:0] cause;
  } ent_t;

  ent_t        mem     [DEPTH];
  logic [31:0] seq_mem [DEPTH];

  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [31:0]     seq;
  logic [XLEN-1:0] mip_prev;

  ent_t          c0, c1, mk;
  ent_t          slot0, slot1, slot2;
  logic          v0, v1, chg;
  logic [1:0]    n;
  logic [1:0]    acc_n;
  logic [CW:0]   need;
  logic          accept;
  logic          deq;
  logic [CW-1:0] count_n;
  logic [PW-1:0] wp1, wp2;

  assign v0  = commit_valid_i[0];
  assign v1  = commit_valid_i[1];
  assign chg = (mip_i != mip_prev);

  always_comb begin
    c0       = '0;
    c0.pc    = commit_pc_i[0 +: XLEN];
    c0.ins   = commit_ins_i[0 +: 32];
    c0.dst   = commit_dst_i[0 +: 5];
    c0.we    = commit_we_i[0];
    c0.data  = commit_data_i[0 +: XLEN];
    c0.xcpt  = commit_xcpt_i[0];
    c0.cause = commit_cause_i[0 +: XLEN];
    c1       = '0;
    c1.pc    = commit_pc_i[XLEN +: XLEN];
    c1.ins   = commit_ins_i[32 +: 32];
    c1.dst   = commit_dst_i[5 +: 5];
    c1.we    = commit_we_i[1];
    c1.data  = commit_data_i[XLEN +: XLEN];
    c1.xcpt  = commit_xcpt_i[1];
    c1.cause = commit_cause_i[XLEN +: XLEN];
    mk       = '0;
    mk.kind  = 1'b1;
    mk.data  = mip_i;
  end

  // Slots are packed densely: commits first, marker last.
  always_comb begin
    slot0 = v0 ? c0 : (v1 ? c1 : mk);
    slot1 = (v0 && v1) ? c1 : mk;
    slot2 = mk;
    n     = {1'b0, v0} + {1'b0, v1} + {1'b0, chg};
  end

  // Space is judged on occupancy before this cycle's dequeue.
  always_comb begin
    need    = {1'b0, count} + {{(CW-1){1'b0}}, n};
    accept  = (need <= (CW+1)'(DEPTH));
    acc_n   = accept ? n : 2'd0;
    deq     = out_valid_o && out_ready_i;
    count_n = count + {{(CW-2){1'b0}}, acc_n}
                    - {{(CW-1){1'b0}}, deq};
    wp1     = wr_ptr + PW'(1);
    wp2     = wr_ptr + PW'(2);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      seq        <= '0;
      mip_prev   <= '0;
      stall_o    <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      wr_ptr  <= wr_ptr + {{(PW-2){1'b0}}, acc_n};
      if (deq)
        rd_ptr <= rd_ptr + PW'(1);
      count   <= count_n;
      seq     <= seq + {30'b0, acc_n};
      stall_o <= (count_n > CW'(DEPTH - 3));
      if (accept && chg)
        mip_prev <= mip_i;
      if (!accept)
        overflow_o <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept && (n != 2'd0)) begin
      mem[wr_ptr]     <= slot0;
      seq_mem[wr_ptr] <= seq;
    end
    if (accept && (n >= 2'd2)) begin
      mem[wp1]     <= slot1;
      seq_mem[wp1] <= seq + 32'd1;
    end
    if (accept && (n == 2'd3)) begin
      mem[wp2]     <= slot2;
      seq_mem[wp2] <= seq + 32'd2;
    end
  end

  ent_t head;

  assign head        = mem[rd_ptr];
  assign out_valid_o = (count != '0);
  assign out_kind_o  = head.kind;
  assign out_pc_o    = head.pc;
  assign out_ins_o   = head.ins;
  assign out_dst_o   = head.dst;
  assign out_we_o    = head.we;
  assign out_data_o  = head.data;
  assign out_xcpt_o  = head.xcpt;
  assign out_cause_o = head.cause;
  assign out_seq_o   = seq_mem[rd_ptr];
  assign out_hart_o  = 32'(HART_ID);
  assign count_o     = count;

endmodule

// File: tb/tb_cosim_commit_queue.sv
// Directed bench for cosim_commit_queue with DEPTH=16, XLEN=64.
// Inputs change 1ns after each rising edge; outputs are checked there too.
module tb_cosim_commit_queue;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   cv;
  logic [127:0] cpc;
  logic [63:0]  cins;
  logic [9:0]   cdst;
  logic [1:0]   cwe;
  logic [127:0] cdata;
  logic [1:0]   cx;
  logic [127:0] ccause;
  logic [63:0]  mip;
  logic         out_valid_o;
  logic         out_ready_i;
  logic         out_kind_o;
  logic [63:0]  out_pc_o;
  logic [31:0]  out_ins_o;
  logic [4:0]   out_dst_o;
  logic         out_we_o;
  logic [63:0]  out_data_o;
  logic         out_xcpt_o;
  logic [63:0]  out_cause_o;
  logic [31:0]  out_seq_o;
  logic [31:0]  out_hart_o;
  logic [4:0]   count_o;
  logic         stall_o;
  logic         overflow_o;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  cosim_commit_queue #(.DEPTH(16), .XLEN(64), .HART_ID(0)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .commit_valid_i (cv),
    .commit_pc_i    (cpc),
    .commit_ins_i   (cins),
    .commit_dst_i   (cdst),
    .commit_we_i    (cwe),
    .commit_data_i  (cdata),
    .commit_xcpt_i  (cx),
    .commit_cause_i (ccause),
    .mip_i          (mip),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready_i),
    .out_kind_o     (out_kind_o),
    .out_pc_o       (out_pc_o),
    .out_ins_o      (out_ins_o),
    .out_dst_o      (out_dst_o),
    .out_we_o       (out_we_o),
    .out_data_o     (out_data_o),
    .out_xcpt_o     (out_xcpt_o),
    .out_cause_o    (out_cause_o),
    .out_seq_o      (out_seq_o),
    .out_hart_o     (out_hart_o),
    .count_o        (count_o),
    .stall_o        (stall_o),
    .overflow_o     (overflow_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic lane(input int l, input logic [63:0] pc,
                      input logic [63:0] data);
    cv[l]              = 1'b1;
    cpc[l*64 +: 64]    = pc;
    cins[l*32 +: 32]   = 32'h0000_0013;
    cdst[l*5 +: 5]     = 5'd0;
    cwe[l]             = 1'b0;
    cdata[l*64 +: 64]  = data;
    cx[l]              = 1'b0;
    ccause[l*64 +: 64] = 64'd0;
  endtask

  task automatic do_reset();
    cv    = 2'b00;
    mip   = 64'd0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  int pushed;
  int rx;
  int cyc;

  initial begin
    cv = '0; cpc = '0; cins = '0; cdst = '0; cwe = '0;
    cdata = '0; cx = '0; ccause = '0; mip = '0;
    out_ready_i = 1'b0;
    do_reset();
    chk("rst_count", 64'(count_o), 64'd0);
    chk("rst_valid", 64'(out_valid_o), 64'd0);
    chk("rst_stall", 64'(stall_o), 64'd0);
    chk("rst_ovf", 64'(overflow_o), 64'd0);
    chk("hart", 64'(out_hart_o), 64'd0);

    // single commit, consumed on the next edge
    out_ready_i = 1'b1;
    lane(0, 64'h8000_0000, 64'd0);
    step();
    cv = 2'b00;
    chk("s_valid", 64'(out_valid_o), 64'd1);
    chk("s_kind", 64'(out_kind_o), 64'd0);
    chk("s_pc", out_pc_o, 64'h8000_0000);
    chk("s_ins", 64'(out_ins_o), 64'h13);
    chk("s_seq", 64'(out_seq_o), 64'd0);
    step();
    chk("s_count0", 64'(count_o), 64'd0);
    chk("s_valid0", 64'(out_valid_o), 64'd0);

    // dual retire plus mip change in one cycle
    do_reset();
    out_ready_i = 1'b0;
    lane(0, 64'h100, 64'hA0);
    lane(1, 64'h104, 64'hA1);
    mip = 64'h800;
    step();
    cv = 2'b00;
    chk("d_count", 64'(count_o), 64'd3);
    chk("d0_pc", out_pc_o, 64'h100);
    chk("d0_seq", 64'(out_seq_o), 64'd0);
    chk("d0_kind", 64'(out_kind_o), 64'd0);
    out_ready_i = 1'b1;
    step();
    chk("d1_pc", out_pc_o, 64'h104);
    chk("d1_seq", 64'(out_seq_o), 64'd1);
    chk("d1_data", out_data_o, 64'hA1);
    step();
    chk("dm_kind", 64'(out_kind_o), 64'd1);
    chk("dm_data", out_data_o, 64'h800);
    chk("dm_pc", out_pc_o, 64'd0);
    chk("dm_ins", 64'(out_ins_o), 64'd0);
    chk("dm_seq", 64'(out_seq_o), 64'd2);
    step();
    chk("d_empty", 64'(count_o), 64'd0);

    // lane1 only
    do_reset();
    out_ready_i = 1'b0;
    lane(1, 64'h200, 64'hB0);
    step();
    cv = 2'b00;
    chk("l1_count", 64'(count_o), 64'd1);
    chk("l1_pc", out_pc_o, 64'h200);
    chk("l1_seq", 64'(out_seq_o), 64'd0);
    step();
    chk("l1_hold_pc", out_pc_o, 64'h200);

    // fill to 15 with ready low
    for (int k = 2; k <= 15; k++) begin
      cv = 2'b00;
      lane(0, 64'h1000 + 64'(k - 1), 64'd0);
      step();
      chk("f_count", 64'(count_o), 64'(k));
      chk("f_stall", 64'(stall_o), 64'(k >= 14));
    end
    cv = 2'b00;
    chk("f_ovf0", 64'(overflow_o), 64'd0);
    lane(0, 64'h2000, 64'd0);
    lane(1, 64'h2004, 64'd0);
    step();
    cv = 2'b00;
    chk("o_count", 64'(count_o), 64'd15);
    chk("o_ovf", 64'(overflow_o), 64'd1);
    lane(0, 64'h3000, 64'd0);
    step();
    cv = 2'b00;
    chk("o_count16", 64'(count_o), 64'd16);
    chk("o_sticky", 64'(overflow_o), 64'd1);

    // full with simultaneous dequeue: commit still rejected
    out_ready_i = 1'b1;
    lane(0, 64'h4000, 64'd0);
    step();
    cv = 2'b00;
    chk("fd_count", 64'(count_o), 64'd15);
    chk("fd_ovf", 64'(overflow_o), 64'd1);
    for (int j = 1; j <= 15; j++) begin
      chk("dr_seq", 64'(out_seq_o), 64'(j));
      chk("dr_pc", out_pc_o,
          (j < 15) ? 64'h1000 + 64'(j) : 64'h3000);
      step();
    end
    chk("dr_empty", 64'(out_valid_o), 64'd0);
    chk("dr_count", 64'(count_o), 64'd0);

    // 40 entries through a half-rate consumer
    do_reset();
    chk("w_ovf_rst", 64'(overflow_o), 64'd0);
    pushed = 0;
    rx = 0;
    cyc = 0;
    while (rx < 40 && cyc < 400) begin
      cv = 2'b00;
      out_ready_i = cyc[0];
      if (pushed < 40 && !stall_o) begin
        lane(0, 64'h9000 + 64'(pushed), 64'hD000 + 64'(pushed));
        pushed++;
      end
      if (out_valid_o && out_ready_i) begin
        chk("w_seq", 64'(out_seq_o), 64'(rx));
        chk("w_data", out_data_o, 64'hD000 + 64'(rx));
        rx++;
      end
      step();
      cyc++;
    end
    cv = 2'b00;
    chk("w_rx", 64'(rx), 64'd40);
    chk("w_ovf", 64'(overflow_o), 64'd0);
    chk("w_count", 64'(count_o), 64'd0);

    // reset with entries in flight
    out_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      lane(0, 64'h7000 + 64'(k), 64'd0);
      step();
    end
    cv = 2'b00;
    chk("m_count", 64'(count_o), 64'd3);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("m_valid", 64'(out_valid_o), 64'd0);
    chk("m_cnt0", 64'(count_o), 64'd0);
    lane(0, 64'h7100, 64'd0);
    step();
    cv = 2'b00;
    chk("m_seq", 64'(out_seq_o), 64'd0);
    chk("m_pc", out_pc_o, 64'h7100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
